rf_alu_sequencer: RTL and testbench

Read-side controller for the ALU/register-file datapath. On each accepted command it reads two source registers through the register file's single read port and latches them as ALU operands. It then presents them to the ALU with the opcode and writes the ALU result back to a destination register. It sits above the ALU + register file pair and owns their `read_addr`, `A`, `B`, `opcode`, `write_addr` and `write_enable` inputs.

---
 rtl/alu_reg_pkg.sv | 22 ++
 rtl/rf_alu_sequencer.sv | 130 +++++++++++++
 tb/tb_rf_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reg_pkg.sv
// Shared widths, sequencer state encoding and ALU opcode values for the
// ALU/register-file datapath.
package alu_reg_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } seq_state_t;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_W-1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/rf_alu_sequencer.sv
// Read-side controller: fetches two operands through the single register-file
// read port, drives the ALU, and writes the result back to the destination.
module rf_alu_sequencer
    import alu_reg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] last_result
);

    seq_state_t        state_r;
    seq_state_t        next_state_s;
    logic [OP_W-1:0]   op_r;
    logic [ADDR_W-1:0] src_a_r;
    logic [ADDR_W-1:0] src_b_r;
    logic [ADDR_W-1:0] dst_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] last_result_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: only IDLE waits; the command path is a fixed walk
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RD_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_A:    next_state_s = RD_B;
            RD_B:    next_state_s = EXEC;
            EXEC:    next_state_s = WB;
            WB:      next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Command latch, operand capture and write-back result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r          <= {OP_W{1'b0}};
            src_a_r       <= {ADDR_W{1'b0}};
            src_b_r       <= {ADDR_W{1'b0}};
            dst_r         <= {ADDR_W{1'b0}};
            a_r           <= {DATA_W{1'b0}};
            b_r           <= {DATA_W{1'b0}};
            last_result_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= cmd_op;
                        src_a_r <= cmd_src_a;
                        src_b_r <= cmd_src_b;
                        dst_r   <= cmd_dst;
                    end
                end
                RD_A:    a_r           <= rf_read_data;
                RD_B:    b_r           <= rf_read_data;
                WB:      last_result_r <= alu_result;
                default: ;
            endcase
        end
    end

    // Moore output decode; write enable falls with the state on async reset
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        rf_write_enable = 1'b0;
        rf_read_addr    = {ADDR_W{1'b0}};
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            RD_A: begin
                busy         = 1'b1;
                rf_read_addr = src_a_r;
            end
            RD_B: begin
                busy         = 1'b1;
                rf_read_addr = src_b_r;
            end
            EXEC: begin
                busy = 1'b1;
            end
            WB: begin
                busy            = 1'b1;
                done            = 1'b1;
                rf_write_enable = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign alu_a         = a_r;
    assign alu_b         = b_r;
    assign alu_opcode    = op_r;
    assign rf_write_addr = dst_r;
    assign last_result   = last_result_r;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer with a behavioural register file and ALU around it.
module tb_rf_alu_sequencer;
    import alu_reg_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic              busy, done;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] rf_write_addr;
    logic              rf_write_enable;
    logic [DATA_W-1:0] last_result;

    logic [DATA_W-1:0] rf_mem  [8];
    logic [DATA_W-1:0] ref_mem [8];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = 3'd0;
    logic [DATA_W-1:0] pre_data = 8'd0;

    typedef struct {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] val;
    } exp_t;
    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int we_count     = 0;
    logic              prev_done = 1'b0;
    logic [DATA_W-1:0] prev_val  = 8'd0;

    always #5 clk = ~clk;

    rf_alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .busy(busy), .done(done), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rf_write_addr(rf_write_addr), .rf_write_enable(rf_write_enable),
        .last_result(last_result)
    );

    function automatic logic [DATA_W-1:0] model_alu(input logic [OP_W-1:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 8'd0;
        endcase
    endfunction

    assign rf_read_data = rf_mem[rf_read_addr];
    assign alu_result   = model_alu(alu_opcode, alu_a, alu_b);

    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_write_addr] <= alu_result;
        else if (pre_we)     rf_mem[pre_addr]      <= pre_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each write-back, check last_result one cycle later
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) check_eq("last_result", 32'(last_result), 32'(prev_val));
            prev_done = 1'b0;
            if (rf_write_enable) we_count++;
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("wb_addr", 32'(rf_write_addr), 32'(e.dst));
                    check_eq("wb_data", 32'(alu_result), 32'(e.val));
                    check_eq("wb_we", 32'(rf_write_enable), 32'd1);
                    prev_done = 1'b1;
                    prev_val  = e.val;
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic push_cmd(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d);
        logic [DATA_W-1:0] v;
        v = model_alu(op, ref_mem[a], ref_mem[b]);
        ref_mem[d] = v;
        sb.push_back('{d, v});
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk);
        ref_mem[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic set_cmd(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d);
        cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 5 (IDLE again)
    task automatic run_cmd(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d);
        logic [ADDR_W-1:0] ra;
        set_cmd(op, a, b, d);
        start = 1'b1;
        push_cmd(op, a, b, d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            ra = (c == 1) ? a : (c == 2) ? b : 3'd0;
            check_eq($sformatf("busy_c%0d", c), 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("done_c%0d", c), 32'(done), (c == 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("raddr_c%0d", c), 32'(rf_read_addr), 32'(ra));
        end
    endtask

    initial begin
        int w0;
        int n_done;
        int dc[3];

        reset = 1'b0; start = 1'b0;
        set_cmd(OP_ADD, 3'd0, 3'd0, 3'd0);
        #2;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_we", 32'(rf_write_enable), 32'd0);
        check_eq("rst_last", 32'(last_result), 32'd0);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_op", 32'(alu_opcode), 32'd0);
        check_eq("rst_raddr", 32'(rf_read_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) preload(3'(i), 8'd0);

        // Basic ADD
        preload(3'd1, 8'h12);
        preload(3'd2, 8'h34);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3);
        check_eq("r3_add", 32'(rf_mem[3]), 32'h46);

        // Wrap-around then back-to-back read-after-write
        preload(3'd1, 8'hF0);
        preload(3'd2, 8'h20);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd1);
        run_cmd(OP_SUB, 3'd1, 3'd1, 3'd4);
        check_eq("r1_wrap", 32'(rf_mem[1]), 32'h10);
        check_eq("r4_sub", 32'(rf_mem[4]), 32'h00);

        // start pulses during an active command are ignored
        w0 = we_count;
        set_cmd(OP_ADD, 3'd1, 3'd2, 3'd7);
        start = 1'b1;
        push_cmd(OP_ADD, 3'd1, 3'd2, 3'd7);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        set_cmd(OP_OR, 3'd3, 3'd4, 3'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("ignored_start_we", 32'(we_count - w0), 32'd1);

        // start held for 15 cycles
        n_done = 0;
        for (int i = 0; i < 3; i++) dc[i] = 0;
        set_cmd(OP_OR, 3'd3, 3'd2, 3'd6);
        start = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(OP_OR, 3'd3, 3'd2, 3'd6);
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done) begin
                if (n_done < 3) dc[n_done] = c;
                n_done++;
            end
            if (c == 15) start = 1'b0;
        end
        check_eq("held_ndone", 32'(n_done), 32'd3);
        check_eq("held_d0", 32'(dc[0]), 32'd4);
        check_eq("held_d1", 32'(dc[1]), 32'd9);
        check_eq("held_d2", 32'(dc[2]), 32'd14);

        // Async reset during EXEC aborts without a write
        preload(3'd6, 8'h77);
        set_cmd(OP_ADD, 3'd1, 3'd2, 3'd6);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("exec_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_we", 32'(rf_write_enable), 32'd0);
        check_eq("abort_last", 32'(last_result), 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("after_abort_busy", 32'(busy), 32'd0);
        check_eq("r6_kept", 32'(rf_mem[6]), 32'h77);
        run_cmd(OP_ADD, 3'd6, 3'd6, 3'd7);

        // AND with identical sources, destination overlaps source
        preload(3'd5, 8'hA5);
        run_cmd(OP_AND, 3'd5, 3'd5, 3'd5);
        check_eq("r5_and", 32'(rf_mem[5]), 32'hA5);

        @(negedge clk);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("final_r%0d", i), 32'(rf_mem[i]), 32'(ref_mem[i]));
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
